// File: rtl/noc_vc_input_unit_if.sv
// Link and switch-allocator signals of one NoC router input port.
// slave is the input unit's view; master is the upstream/allocator side.
interface noc_vc_input_unit_if #(
    parameter int unsigned DATA_W = 35,
    parameter int unsigned NUM_VC = 2,
    parameter int unsigned VCW    = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
);
    logic [DATA_W-1:0]        idata;
    logic                     ivalid;
    logic [VCW-1:0]           ivch;
    logic [NUM_VC-1:0]        oack;
    logic [NUM_VC-1:0]        ordy;
    logic [NUM_VC-1:0]        olck;
    logic [NUM_VC-1:0]        vc_valid;
    logic [NUM_VC*DATA_W-1:0] vc_data;
    logic [NUM_VC*3-1:0]      vc_port;
    logic [NUM_VC-1:0]        vc_grant;

    modport master (
        output idata, ivalid, ivch, vc_grant,
        input  oack, ordy, olck, vc_valid, vc_data, vc_port
    );

    modport slave (
        input  idata, ivalid, ivch, vc_grant,
        output oack, ordy, olck, vc_valid, vc_data, vc_port
    );
endinterface

// File: rtl/noc_vc_input_unit.sv
// Mesh NoC router input port: per-VC flit FIFOs with credit return, packet lock
// tracking and XY route computation feeding the switch allocator.
module noc_vc_input_unit #(
    parameter int unsigned DATA_W  = 35,
    parameter int unsigned COORD_W = 2,
    parameter int unsigned NUM_VC  = 2,
    parameter int unsigned DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic [COORD_W-1:0] my_xpos,
    input  logic [COORD_W-1:0] my_ypos,
    noc_vc_input_unit_if.slave bus,
    output logic [2:0]         err
);
    localparam int unsigned VCW  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int unsigned PTRW = $clog2(DEPTH);
    localparam int unsigned CNTW = PTRW + 1;
    localparam logic [CNTW-1:0] FullCnt = CNTW'(DEPTH);

    localparam logic [2:0] PortLocal = 3'd0;
    localparam logic [2:0] PortNorth = 3'd1;
    localparam logic [2:0] PortEast  = 3'd2;
    localparam logic [2:0] PortSouth = 3'd3;
    localparam logic [2:0] PortWest  = 3'd4;

    localparam logic [1:0] TypeHead = 2'b01;
    localparam logic [1:0] TypeTail = 2'b10;

    typedef enum logic {StIdle, StLocked} lock_e;

    logic [DATA_W-1:0] mem_q    [NUM_VC][DEPTH];
    logic [PTRW-1:0]   wr_ptr_q [NUM_VC];
    logic [PTRW-1:0]   rd_ptr_q [NUM_VC];
    logic [CNTW-1:0]   count_q  [NUM_VC];
    logic [2:0]        route_q  [NUM_VC];
    lock_e             lock_q   [NUM_VC];
    logic [NUM_VC-1:0] oack_q;
    logic [2:0]        err_q;

    logic [VCW-1:0]    wr_vc;
    logic              vc_in_range;
    logic [1:0]        in_type;
    logic [NUM_VC-1:0] grant_lsb;
    logic [NUM_VC-1:0] wr_sel;
    logic [NUM_VC-1:0] wr_en;
    logic [NUM_VC-1:0] full;
    logic [NUM_VC-1:0] empty;
    logic [NUM_VC-1:0] pop;
    logic [DATA_W-1:0] front      [NUM_VC];
    logic [2:0]        head_route [NUM_VC];

    // Unsigned dimension-ordered compare: X is resolved before Y.
    function automatic logic [2:0] xy_route(input logic [2*COORD_W-1:0] dest,
                                            input logic [COORD_W-1:0]   cx,
                                            input logic [COORD_W-1:0]   cy);
        logic [COORD_W-1:0] dx;
        logic [COORD_W-1:0] dy;
        dx = dest[COORD_W-1:0];
        dy = dest[2*COORD_W-1:COORD_W];
        if (dx > cx)      return PortEast;
        else if (dx < cx) return PortWest;
        else if (dy > cy) return PortNorth;
        else if (dy < cy) return PortSouth;
        return PortLocal;
    endfunction

    assign wr_vc       = bus.ivch;
    assign vc_in_range = 32'(wr_vc) < NUM_VC;
    assign in_type     = bus.idata[DATA_W-1:DATA_W-2];
    // Only the lowest requested VC may pop in a cycle.
    assign grant_lsb   = bus.vc_grant & (~bus.vc_grant + NUM_VC'(1));

    always_comb begin
        full   = '0;
        empty  = '0;
        wr_sel = '0;
        wr_en  = '0;
        pop    = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            full[v]       = count_q[v] == FullCnt;
            empty[v]      = count_q[v] == '0;
            wr_sel[v]     = bus.ivalid && vc_in_range && (wr_vc == VCW'(v));
            wr_en[v]      = wr_sel[v] && !full[v];
            pop[v]        = grant_lsb[v] && !empty[v];
            front[v]      = mem_q[v][rd_ptr_q[v]];
            head_route[v] = xy_route(front[v][2*COORD_W-1:0], my_xpos, my_ypos);
        end
    end

    always_comb begin
        bus.vc_data  = '0;
        bus.vc_port  = '0;
        bus.vc_valid = '0;
        bus.ordy     = '0;
        bus.olck     = '0;
        bus.oack     = oack_q;
        for (int v = 0; v < NUM_VC; v++) begin
            bus.vc_data[v*DATA_W +: DATA_W] = front[v];
            bus.vc_valid[v] = !empty[v];
            bus.ordy[v]     = !full[v];
            bus.olck[v]     = lock_q[v] == StLocked;
            // Heads (01/11) route live; body/tail reuse the route latched at head pop.
            if (empty[v])                   bus.vc_port[v*3 +: 3] = PortLocal;
            else if (front[v][DATA_W-2])    bus.vc_port[v*3 +: 3] = head_route[v];
            else                            bus.vc_port[v*3 +: 3] = route_q[v];
        end
    end

    assign err = err_q;

    // Flit storage carries no reset; validity comes from the counts.
    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VC; v++) begin
            if (wr_en[v]) mem_q[v][wr_ptr_q[v]] <= bus.idata;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
                count_q[v]  <= '0;
                route_q[v]  <= PortLocal;
                lock_q[v]   <= StIdle;
            end
            oack_q <= '0;
            err_q  <= '0;
        end else begin
            oack_q <= pop;
            err_q  <= err_q | {bus.ivalid && !vc_in_range,
                               |(grant_lsb & empty),
                               |(wr_sel & full)};
            for (int v = 0; v < NUM_VC; v++) begin
                if (wr_en[v]) wr_ptr_q[v] <= wr_ptr_q[v] + PTRW'(1);
                if (pop[v]) begin
                    rd_ptr_q[v] <= rd_ptr_q[v] + PTRW'(1);
                    if (front[v][DATA_W-1:DATA_W-2] == TypeHead) route_q[v] <= head_route[v];
                end
                count_q[v] <= count_q[v] + CNTW'(wr_en[v]) - CNTW'(pop[v]);
                if (wr_en[v]) begin
                    unique case (lock_q[v])
                        StIdle:   if (in_type == TypeHead) lock_q[v] <= StLocked;
                        StLocked: if (in_type == TypeTail) lock_q[v] <= StIdle;
                        default:  lock_q[v] <= StIdle;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_noc_vc_input_unit.sv
// Self-checking bench for noc_vc_input_unit: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_noc_vc_input_unit;
    localparam int unsigned DW    = 35;
    localparam int unsigned CW    = 2;
    localparam int unsigned NV    = 2;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_;
    logic [CW-1:0] my_x;
    logic [CW-1:0] my_y;
    logic [2:0]    err;
    logic [2:0]    err3;
    int            n_cmp = 0;
    int            n_fail = 0;

    noc_vc_input_unit_if #(.DATA_W(DW), .NUM_VC(NV), .VCW(1)) bus ();
    noc_vc_input_unit_if #(.DATA_W(DW), .NUM_VC(3),  .VCW(2)) bus3 ();

    noc_vc_input_unit #(.DATA_W(DW), .COORD_W(CW), .NUM_VC(NV), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_(rst_), .my_xpos(my_x), .my_ypos(my_y), .bus(bus), .err(err)
    );

    noc_vc_input_unit #(.DATA_W(DW), .COORD_W(CW), .NUM_VC(3), .DEPTH(DEPTH)) dut3 (
        .clk(clk), .rst_(rst_), .my_xpos(my_x), .my_ypos(my_y), .bus(bus3), .err(err3)
    );

    always #5 clk = ~clk;

    // Reference model: one queue per VC, plus route latch, lock flag and sticky errors.
    logic [DW-1:0] mq [NV][$];
    logic [2:0]    m_latch [NV];
    logic          m_lock  [NV];
    logic [2:0]    m_err;
    logic [NV-1:0] m_oack;

    function automatic logic [2:0] ref_route(input logic [DW-1:0] f);
        int dx, dy, mx, my;
        dx = int'(f[1:0]); dy = int'(f[3:2]); mx = int'(my_x); my = int'(my_y);
        if (dx > mx) return 3'd2;
        if (dx < mx) return 3'd4;
        if (dy > my) return 3'd1;
        if (dy < my) return 3'd3;
        return 3'd0;
    endfunction

    function automatic logic [2:0] exp_port(input int v);
        logic [DW-1:0] f;
        logic [1:0]    t;
        if (mq[v].size() == 0) return 3'd0;
        f = mq[v][0];
        t = f[DW-1:DW-2];
        if (t == 2'b01 || t == 2'b11) return ref_route(f);
        return m_latch[v];
    endfunction

    function automatic logic [NV-1:0] exp_valid();
        logic [NV-1:0] r;
        for (int v = 0; v < NV; v++) r[v] = mq[v].size() != 0;
        return r;
    endfunction

    function automatic logic [NV-1:0] exp_ordy();
        logic [NV-1:0] r;
        for (int v = 0; v < NV; v++) r[v] = mq[v].size() < DEPTH;
        return r;
    endfunction

    function automatic logic [NV-1:0] exp_lock();
        logic [NV-1:0] r;
        for (int v = 0; v < NV; v++) r[v] = m_lock[v];
        return r;
    endfunction

    task automatic model_clear();
        for (int v = 0; v < NV; v++) begin
            mq[v].delete();
            m_latch[v] = 3'd0;
            m_lock[v]  = 1'b0;
        end
        m_err  = 3'b000;
        m_oack = '0;
    endtask

    // Drive one cycle of stimulus, advance the model, sample 1 time unit after the edge.
    task automatic step(input logic valid, input int ch, input logic [DW-1:0] d,
                        input logic [NV-1:0] g);
        int            gi;
        logic          do_wr;
        logic [DW-1:0] f;
        logic [1:0]    t;
        bus.ivalid = valid; bus.ivch = 1'(ch); bus.idata = d; bus.vc_grant = g;
        gi = -1;
        for (int v = NV - 1; v >= 0; v--) if (g[v]) gi = v;
        do_wr = valid && (mq[ch].size() < DEPTH);
        if (valid && !do_wr) m_err[0] = 1'b1;
        m_oack = '0;
        if (gi >= 0) begin
            if (mq[gi].size() == 0) m_err[1] = 1'b1;
            else begin
                f = mq[gi].pop_front();
                t = f[DW-1:DW-2];
                if (t == 2'b01) m_latch[gi] = ref_route(f);
                m_oack[gi] = 1'b1;
            end
        end
        if (do_wr) begin
            mq[ch].push_back(d);
            t = d[DW-1:DW-2];
            if (t == 2'b01) m_lock[ch] = 1'b1;
            else if (t == 2'b10) m_lock[ch] = 1'b0;
        end
        @(posedge clk); #1;
        bus.ivalid = 1'b0; bus.vc_grant = '0;
    endtask

    task automatic test_reset();
        rst_ = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_ = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (bus.vc_valid !== 2'b00) begin n_fail++; $display("FAIL reset_valid: got %b want 00", bus.vc_valid); end
        n_cmp++; if (bus.ordy !== 2'b11) begin n_fail++; $display("FAIL reset_ordy: got %b want 11", bus.ordy); end
        n_cmp++; if (bus.olck !== 2'b00) begin n_fail++; $display("FAIL reset_olck: got %b want 00", bus.olck); end
        n_cmp++; if (bus.vc_port !== 6'd0) begin n_fail++; $display("FAIL reset_port: got %h want 0", bus.vc_port); end
        n_cmp++; if (bus.oack !== 2'b00) begin n_fail++; $display("FAIL reset_oack: got %b want 00", bus.oack); end
        n_cmp++; if (err !== 3'b000) begin n_fail++; $display("FAIL reset_err: got %b want 000", err); end
    endtask

    task automatic test_head_tail();
        logic [DW-1:0] d;
        my_x = 2'd1; my_y = 2'd1;
        d = {2'b11, 29'h0ABCDE1, 4'b0111};   // dest x=3, y=1
        step(1'b1, 0, d, 2'b00);
        n_cmp++; if (bus.vc_valid[0] !== 1'b1) begin n_fail++; $display("FAIL ht_valid: got %b want 1", bus.vc_valid[0]); end
        n_cmp++; if (bus.vc_port[2:0] !== 3'd2) begin n_fail++; $display("FAIL ht_port: got %0d want 2", bus.vc_port[2:0]); end
        n_cmp++; if (bus.vc_data[DW-1:0] !== d) begin n_fail++; $display("FAIL ht_data: got %h want %h", bus.vc_data[DW-1:0], d); end
        step(1'b0, 0, '0, 2'b01);
        n_cmp++; if (bus.oack !== 2'b01) begin n_fail++; $display("FAIL ht_oack: got %b want 01", bus.oack); end
        n_cmp++; if (bus.vc_valid[0] !== 1'b0) begin n_fail++; $display("FAIL ht_empty: got %b want 0", bus.vc_valid[0]); end
        step(1'b0, 0, '0, 2'b00);
        n_cmp++; if (bus.oack !== 2'b00) begin n_fail++; $display("FAIL ht_oack_pulse: got %b want 00", bus.oack); end
    endtask

    task automatic test_packet();
        logic [DW-1:0] pkt [4];
        pkt[0] = {2'b01, 29'h1234567, 4'b0001};  // head, dest x=1, y=0
        pkt[1] = {2'b00, 33'(32'hDEAD_BEEF)};
        pkt[2] = {2'b00, 33'(32'h0BAD_F00D)};
        pkt[3] = {2'b10, 33'(32'h7777_0002)};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1, pkt[i], 2'b00);
            n_cmp++;
            if (bus.olck[1] !== (i < 3)) begin n_fail++; $display("FAIL pkt_olck[%0d]: got %b want %b", i, bus.olck[1], i < 3); end
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (bus.vc_port[5:3] !== 3'd3) begin n_fail++; $display("FAIL pkt_port[%0d]: got %0d want 3", i, bus.vc_port[5:3]); end
            n_cmp++; if (bus.vc_data[DW +: DW] !== pkt[i]) begin n_fail++; $display("FAIL pkt_data[%0d]: got %h want %h", i, bus.vc_data[DW +: DW], pkt[i]); end
            step(1'b0, 0, '0, 2'b10);
            n_cmp++; if (bus.oack !== 2'b10) begin n_fail++; $display("FAIL pkt_oack[%0d]: got %b want 10", i, bus.oack); end
        end
        n_cmp++; if (bus.vc_valid[1] !== 1'b0) begin n_fail++; $display("FAIL pkt_drained: got %b want 0", bus.vc_valid[1]); end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] f [5];
        for (int i = 0; i < 5; i++) f[i] = {2'b00, 33'(32'h100 + 32'(i))};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 0, f[i], 2'b00);
            if (i == 3) begin
                n_cmp++; if (bus.ordy[0] !== 1'b0) begin n_fail++; $display("FAIL ovf_ordy: got %b want 0", bus.ordy[0]); end
            end
        end
        n_cmp++; if (err !== 3'b001) begin n_fail++; $display("FAIL ovf_err: got %b want 001", err); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (bus.vc_data[DW-1:0] !== f[i]) begin n_fail++; $display("FAIL ovf_drain[%0d]: got %h want %h", i, bus.vc_data[DW-1:0], f[i]); end
            step(1'b0, 0, '0, 2'b01);
        end
        n_cmp++; if (bus.vc_valid[0] !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %b want 0", bus.vc_valid[0]); end
    endtask

    task automatic test_full_pop();
        logic [DW-1:0] f [5];
        for (int i = 0; i < 5; i++) f[i] = {2'b00, 33'(32'h2000 + 32'(i))};
        for (int i = 0; i < 4; i++) step(1'b1, 0, f[i], 2'b00);
        step(1'b1, 0, f[4], 2'b01);                 // full: write refused, pop proceeds
        n_cmp++; if (bus.ordy[0] !== 1'b1) begin n_fail++; $display("FAIL fp_ordy: got %b want 1", bus.ordy[0]); end
        n_cmp++; if (err[0] !== 1'b1) begin n_fail++; $display("FAIL fp_err: got %b want 1", err[0]); end
        n_cmp++; if (bus.oack !== 2'b01) begin n_fail++; $display("FAIL fp_oack: got %b want 01", bus.oack); end
        for (int i = 1; i < 4; i++) begin
            n_cmp++; if (bus.vc_data[DW-1:0] !== f[i]) begin n_fail++; $display("FAIL fp_drain[%0d]: got %h want %h", i, bus.vc_data[DW-1:0], f[i]); end
            step(1'b0, 0, '0, 2'b01);
        end
        n_cmp++; if (bus.vc_valid[0] !== 1'b0) begin n_fail++; $display("FAIL fp_count3: got %b want 0", bus.vc_valid[0]); end
        step(1'b1, 0, f[0], 2'b00);
        step(1'b1, 0, f[1], 2'b00);
        step(1'b1, 0, f[2], 2'b01);                 // partial: write and pop together
        for (int i = 1; i < 3; i++) begin
            n_cmp++; if (bus.vc_data[DW-1:0] !== f[i]) begin n_fail++; $display("FAIL fp_part[%0d]: got %h want %h", i, bus.vc_data[DW-1:0], f[i]); end
            step(1'b0, 0, '0, 2'b01);
        end
        n_cmp++; if (bus.vc_valid[0] !== 1'b0) begin n_fail++; $display("FAIL fp_count2: got %b want 0", bus.vc_valid[0]); end
    endtask

    task automatic test_grant_priority();
        step(1'b1, 0, {2'b00, 33'h1_0000_00AA}, 2'b00);
        step(1'b1, 1, {2'b00, 33'h1_0000_00BB}, 2'b00);
        step(1'b0, 0, '0, 2'b11);
        n_cmp++; if (bus.oack !== 2'b01) begin n_fail++; $display("FAIL gp_oack: got %b want 01", bus.oack); end
        n_cmp++; if (bus.vc_valid !== 2'b10) begin n_fail++; $display("FAIL gp_valid: got %b want 10", bus.vc_valid); end
        step(1'b0, 0, '0, 2'b10);
        n_cmp++; if (bus.oack !== 2'b10) begin n_fail++; $display("FAIL gp_oack1: got %b want 10", bus.oack); end
        step(1'b0, 0, '0, 2'b10);
        n_cmp++; if (err !== 3'b011) begin n_fail++; $display("FAIL gp_udf: got %b want 011", err); end
        n_cmp++; if (bus.oack !== 2'b00) begin n_fail++; $display("FAIL gp_no_oack: got %b want 00", bus.oack); end
    endtask

    task automatic test_bad_vch();
        logic [DW-1:0] d;
        d = {2'b11, 33'h0_1234_5678};
        bus3.ivalid = 1'b1; bus3.ivch = 2'd3; bus3.idata = d;
        step(1'b0, 0, '0, 2'b00);
        bus3.ivalid = 1'b0;
        n_cmp++; if (err3 !== 3'b100) begin n_fail++; $display("FAIL bv_err: got %b want 100", err3); end
        n_cmp++; if (bus3.vc_valid !== 3'b000) begin n_fail++; $display("FAIL bv_drop: got %b want 000", bus3.vc_valid); end
        bus3.ivalid = 1'b1; bus3.ivch = 2'd2;
        step(1'b0, 0, '0, 2'b00);
        bus3.ivalid = 1'b0;
        n_cmp++; if (bus3.vc_valid !== 3'b100) begin n_fail++; $display("FAIL bv_vc2: got %b want 100", bus3.vc_valid); end
        n_cmp++; if (bus3.vc_data[2*DW +: DW] !== d) begin n_fail++; $display("FAIL bv_data: got %h want %h", bus3.vc_data[2*DW +: DW], d); end
        bus3.vc_grant = 3'b100;
        step(1'b0, 0, '0, 2'b00);
        bus3.vc_grant = 3'b000;
        n_cmp++; if (bus3.oack !== 3'b100) begin n_fail++; $display("FAIL bv_oack: got %b want 100", bus3.oack); end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1, {2'b01, 33'h0_0000_0005}, 2'b00);
        step(1'b1, 1, {2'b00, 33'h0_0000_0011}, 2'b00);
        step(1'b1, 1, {2'b00, 33'h0_0000_0022}, 2'b00);
        n_cmp++; if (bus.olck !== 2'b10) begin n_fail++; $display("FAIL rm_locked: got %b want 10", bus.olck); end
        #2 rst_ = 1'b0;
        #1;
        n_cmp++; if (bus.vc_valid !== 2'b00) begin n_fail++; $display("FAIL rm_valid: got %b want 00", bus.vc_valid); end
        n_cmp++; if (bus.olck !== 2'b00) begin n_fail++; $display("FAIL rm_olck: got %b want 00", bus.olck); end
        n_cmp++; if (err !== 3'b000) begin n_fail++; $display("FAIL rm_err: got %b want 000", err); end
        model_clear();
        @(negedge clk) rst_ = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 0, '0, 2'b00);
            n_cmp++; if (bus.oack !== 2'b00) begin n_fail++; $display("FAIL rm_oack[%0d]: got %b want 00", i, bus.oack); end
        end
        n_cmp++; if (bus.vc_valid !== 2'b00) begin n_fail++; $display("FAIL rm_after: got %b want 00", bus.vc_valid); end
    endtask

    task automatic test_random();
        logic          valid;
        int            ch;
        logic [DW-1:0] d;
        logic [NV-1:0] g;
        logic [2:0]    ep;
        my_x = CW'($urandom_range(0, 3));
        my_y = CW'($urandom_range(0, 3));
        for (int i = 0; i < 600; i++) begin
            valid = $urandom_range(0, 9) < 7;
            ch    = int'($urandom_range(0, 1));
            d     = DW'({$urandom, $urandom});
            g     = ($urandom_range(0, 2) == 0) ? 2'b00 : NV'($urandom_range(0, 3));
            step(valid, ch, d, g);
            n_cmp++; if (bus.vc_valid !== exp_valid()) begin n_fail++; $display("FAIL rnd_valid @%0d: got %b want %b", i, bus.vc_valid, exp_valid()); end
            n_cmp++; if (bus.ordy !== exp_ordy()) begin n_fail++; $display("FAIL rnd_ordy @%0d: got %b want %b", i, bus.ordy, exp_ordy()); end
            n_cmp++; if (bus.olck !== exp_lock()) begin n_fail++; $display("FAIL rnd_olck @%0d: got %b want %b", i, bus.olck, exp_lock()); end
            n_cmp++; if (bus.oack !== m_oack) begin n_fail++; $display("FAIL rnd_oack @%0d: got %b want %b", i, bus.oack, m_oack); end
            n_cmp++; if (err !== m_err) begin n_fail++; $display("FAIL rnd_err @%0d: got %b want %b", i, err, m_err); end
            for (int v = 0; v < NV; v++) begin
                ep = exp_port(v);
                n_cmp++; if (bus.vc_port[v*3 +: 3] !== ep) begin n_fail++; $display("FAIL rnd_port%0d @%0d: got %0d want %0d", v, i, bus.vc_port[v*3 +: 3], ep); end
                if (mq[v].size() != 0) begin
                    n_cmp++; if (bus.vc_data[v*DW +: DW] !== mq[v][0]) begin n_fail++; $display("FAIL rnd_data%0d @%0d: got %h want %h", v, i, bus.vc_data[v*DW +: DW], mq[v][0]); end
                end
            end
        end
    endtask

    initial begin
        rst_ = 1'b0;
        my_x = 2'd1; my_y = 2'd1;
        bus.ivalid = 1'b0; bus.ivch = '0; bus.idata = '0; bus.vc_grant = '0;
        bus3.ivalid = 1'b0; bus3.ivch = '0; bus3.idata = '0; bus3.vc_grant = '0;
        test_reset();
        test_head_tail();
        test_packet();
        test_overflow();
        test_full_pop();
        test_grant_priority();
        test_bad_vch();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not reach the end, got no finish want finish");
        $fatal(1, "timeout");
    end
endmodule
